// File: rtl/pipeline_controller.sv
// Hazard, flush and memory-stall control for a five-stage pipeline.
// A two-slot scoreboard tracks the destinations of the EXE and MEM instructions.
module pipeline_controller #(
  parameter bit          FWD_DEFAULT = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src_rn,
  input  logic [3:0]  id_src_rm,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic        id_mem_read,
  input  logic [3:0]  id_dest,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        sram_ready,
  input  logic        fwd_cfg_we,
  input  logic        fwd_cfg,
  output logic        hazard,
  output logic        freeze_if,
  output logic        flush,
  output logic        freeze_pipe,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

  mem_state_t state;
  logic [7:0] wait_cnt;
  logic       fwd_mode;

  logic       exe_v, exe_ld, mem_v;
  logic [3:0] exe_dest, mem_dest;

  logic exe_match, mem_match, raw_hazard;

  // Rm only counts as an operand when the instruction really reads it.
  assign exe_match = exe_v & ((exe_dest == id_src_rn) | (id_two_src & (exe_dest == id_src_rm)));
  assign mem_match = mem_v & ((mem_dest == id_src_rn) | (id_two_src & (mem_dest == id_src_rm)));

  assign raw_hazard  = fwd_mode ? (exe_match & exe_ld) : (exe_match | mem_match);
  assign freeze_pipe = mem_req & ~sram_ready;
  assign flush       = branch_taken & ~freeze_pipe;
  assign hazard      = raw_hazard & ~flush;
  assign freeze_if   = hazard | freeze_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_v    <= 1'b0;
      exe_dest <= 4'd0;
      exe_ld   <= 1'b0;
      mem_v    <= 1'b0;
      mem_dest <= 4'd0;
    end else if (!freeze_pipe) begin
      mem_v    <= exe_v;
      mem_dest <= exe_dest;
      exe_v    <= id_wb_en & ~hazard & ~flush;
      exe_dest <= id_dest;
      exe_ld   <= id_mem_read;
    end
  end

  // The watchdog only flags the stall; the pipeline keeps waiting for memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= 8'd0;
          if (freeze_pipe) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sram_ready || !mem_req) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
          end else begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT_CNT) mem_timeout <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_mode     <= FWD_DEFAULT;
      stall_cycles <= 16'd0;
    end else begin
      if (fwd_cfg_we && !freeze_pipe) fwd_mode <= fwd_cfg;
      if (freeze_if && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: per-cycle expected outputs go through
// a scoreboard queue and are compared against the DUT in the low clock phase.
module tb_pipeline_controller;

  localparam int MT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  id_src_rn, id_src_rm, id_dest;
  logic        id_two_src, id_wb_en, id_mem_read;
  logic        branch_taken, mem_req, sram_ready, fwd_cfg_we, fwd_cfg;
  logic        hazard, freeze_if, flush, freeze_pipe, mem_timeout;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        hz, fi, fl, fp, mt;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_sc = 16'd0;
  logic        exp_mt = 1'b0;

  always #5 clk = ~clk;

  pipeline_controller #(.FWD_DEFAULT(1'b0), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .id_src_rn(id_src_rn), .id_src_rm(id_src_rm), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .fwd_cfg_we(fwd_cfg_we), .fwd_cfg(fwd_cfg),
    .hazard(hazard), .freeze_if(freeze_if), .flush(flush),
    .freeze_pipe(freeze_pipe), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    id_src_rn = 4'd0; id_src_rm = 4'd0; id_two_src = 1'b0;
    id_wb_en = 1'b0; id_mem_read = 1'b0; id_dest = 4'd0;
    branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b1;
    fwd_cfg_we = 1'b0; fwd_cfg = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; covers one clock cycle.
  task automatic step(input string tag, input logic hz, input logic fi,
                      input logic fl, input logic fp);
    exp_t e;
    e.tag = tag; e.hz = hz; e.fi = fi; e.fl = fl; e.fp = fp;
    e.mt = exp_mt; e.sc = exp_sc;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    chk({e.tag, ".hazard"},       {15'd0, hazard},      {15'd0, e.hz});
    chk({e.tag, ".freeze_if"},    {15'd0, freeze_if},   {15'd0, e.fi});
    chk({e.tag, ".flush"},        {15'd0, flush},       {15'd0, e.fl});
    chk({e.tag, ".freeze_pipe"},  {15'd0, freeze_pipe}, {15'd0, e.fp});
    chk({e.tag, ".stall_cycles"}, stall_cycles,         e.sc);
    if (!$isunknown(e.mt)) chk({e.tag, ".mem_timeout"}, {15'd0, mem_timeout}, {15'd0, e.mt});
    $display("step %-16s hz=%0b fi=%0b fl=%0b fp=%0b mt=%0b sc=%0d",
             e.tag, hazard, freeze_if, flush, freeze_pipe, mem_timeout, stall_cycles);
    @(posedge clk);
    if (fi === 1'b1 && rst === 1'b1 && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1'b0;
    @(negedge clk);
    step("in_reset0", 0, 0, 0, 0);
    step("in_reset1", 0, 0, 0, 0);
    rst = 1'b1;
    step("first_after_rst", 0, 0, 0, 0);

    // Forwarding off: producer R3 then consumer R3 stalls through EXE and MEM.
    clr(); id_wb_en = 1'b1; id_dest = 4'd3;      step("wr_r3", 0, 0, 0, 0);
    clr(); id_src_rn = 4'd3;                     step("rd_r3_exe", 1, 1, 0, 0);
                                                 step("rd_r3_mem", 1, 1, 0, 0);
                                                 step("rd_r3_free", 0, 0, 0, 0);
    chk("sc_after_r3", stall_cycles, 16'd2);
    clr(); id_wb_en = 1'b1; id_dest = 4'd7;      step("wr_r7", 0, 0, 0, 0);
    clr(); id_src_rn = 4'd1; id_src_rm = 4'd7;   step("rm7_one_src", 0, 0, 0, 0);
    id_two_src = 1'b1;                           step("rm7_two_src", 1, 1, 0, 0);
    clr();                                       step("idle_a", 0, 0, 0, 0);
    // R0 is an ordinary register.
    clr(); id_wb_en = 1'b1; id_dest = 4'd0;      step("wr_r0", 0, 0, 0, 0);
    clr();                                       step("rd_r0_exe", 1, 1, 0, 0);
                                                 step("rd_r0_mem", 1, 1, 0, 0);
                                                 step("rd_r0_free", 0, 0, 0, 0);

    // Forwarding on: only load-use stalls, for one cycle.
    clr(); fwd_cfg_we = 1'b1; fwd_cfg = 1'b1;    step("fwd_on", 0, 0, 0, 0);
    clr(); id_wb_en = 1'b1; id_mem_read = 1'b1; id_dest = 4'd5; step("ld_r5", 0, 0, 0, 0);
    clr(); id_wb_en = 1'b1; id_dest = 4'd6; id_src_rn = 4'd1; id_src_rm = 4'd5; id_two_src = 1'b1;
    step("use_r5", 1, 1, 0, 0);
    step("use_r5_fwd", 0, 0, 0, 0);
    clr(); id_src_rn = 4'd6;                     step("alu_r6_fwd", 0, 0, 0, 0);
    clr();                                       step("idle_b", 0, 0, 0, 0);

    // Forwarding-mode write under freeze is dropped.
    clr(); mem_req = 1'b1; sram_ready = 1'b0; fwd_cfg_we = 1'b1; fwd_cfg = 1'b0;
    step("cfg_drop", 0, 1, 0, 1);
    clr();                                       step("cfg_release", 0, 0, 0, 0);
    clr(); id_wb_en = 1'b1; id_dest = 4'd9;      step("wr_r9", 0, 0, 0, 0);
    clr(); id_src_rn = 4'd9;                     step("rd_r9_still_fwd", 0, 0, 0, 0);
    clr(); fwd_cfg_we = 1'b1; fwd_cfg = 1'b0;    step("fwd_off", 0, 0, 0, 0);

    // Three-cycle memory stall with R4 held in the EXE slot.
    clr(); id_wb_en = 1'b1; id_dest = 4'd4;      step("wr_r4", 0, 0, 0, 0);
    clr(); mem_req = 1'b1; sram_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mem_wait3", 0, 1, 0, 1);
    sram_ready = 1'b1; id_src_rn = 4'd4;         step("mem_done_rd_r4", 1, 1, 0, 0);
    mem_req = 1'b0;                              step("rd_r4_mem", 1, 1, 0, 0);
    clr();                                       step("idle_c", 0, 0, 0, 0);

    // Branch against a RAW hazard: flush wins, bubble enters EXE.
    clr(); id_wb_en = 1'b1; id_dest = 4'd2;      step("wr_r2", 0, 0, 0, 0);
    clr(); branch_taken = 1'b1; id_src_rn = 4'd2; id_wb_en = 1'b1; id_dest = 4'd8;
    step("br_vs_raw", 0, 0, 1, 0);
    clr(); id_src_rn = 4'd8;                     step("exe_bubble", 0, 0, 0, 0);
    // Same case under a memory stall: flush waits for sram_ready.
    clr(); id_wb_en = 1'b1; id_dest = 4'd2;      step("wr_r2_b", 0, 0, 0, 0);
    clr(); branch_taken = 1'b1; id_src_rn = 4'd2; id_wb_en = 1'b1; id_dest = 4'd8;
    mem_req = 1'b1; sram_ready = 1'b0;
    step("br_stall0", 1, 1, 0, 1);
    step("br_stall1", 1, 1, 0, 1);
    sram_ready = 1'b1;                           step("br_release", 0, 0, 1, 0);
    clr(); id_src_rn = 4'd8;                     step("exe_bubble_b", 0, 0, 0, 0);

    // Watchdog: stall held for MT+2 cycles.
    clr(); mem_req = 1'b1; sram_ready = 1'b0;
    for (int i = 0; i < MT + 2; i++) begin
      exp_mt = (i < MT) ? 1'b0 : 1'bx;
      step("mem_long_wait", 0, 1, 0, 1);
    end
    exp_mt = 1'b1;
    sram_ready = 1'b1;                           step("timeout_sticky", 0, 0, 0, 0);
    clr();                                       step("timeout_idle", 0, 0, 0, 0);

    // Reset in the middle of a wait with stall_cycles at 40.
    clr(); mem_req = 1'b1; sram_ready = 1'b0;
    while (exp_sc < 16'd40) step("stall_to_40", 0, 1, 0, 1);
    #2;
    chk("sc_before_rst", stall_cycles, 16'd40);
    rst = 1'b0; mem_req = 1'b0;
    #1;
    chk("rst_async.hazard",       {15'd0, hazard},      16'd0);
    chk("rst_async.freeze_if",    {15'd0, freeze_if},   16'd0);
    chk("rst_async.flush",        {15'd0, flush},       16'd0);
    chk("rst_async.freeze_pipe",  {15'd0, freeze_pipe}, 16'd0);
    chk("rst_async.mem_timeout",  {15'd0, mem_timeout}, 16'd0);
    chk("rst_async.stall_cycles", stall_cycles,         16'd0);
    $display("step %-16s hz=%0b fi=%0b fl=%0b fp=%0b mt=%0b sc=%0d",
             "rst_mid_wait", hazard, freeze_if, flush, freeze_pipe, mem_timeout, stall_cycles);
    exp_sc = 16'd0; exp_mt = 1'b0;
    @(negedge clk);
    clr();                                       step("rst_hold", 0, 0, 0, 0);
    rst = 1'b1;
    mem_req = 1'b1; sram_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst_wait", 0, 1, 0, 1);
    sram_ready = 1'b1;                           step("post_rst_done", 0, 0, 0, 0);
    clr();                                       step("post_rst_idle", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter FWD_DEFAULT, 0, forwarding mode after reset (0 = no forwarding, 1 = forwarding).
REQ-002 Parameter MEM_TIMEOUT, 15, maximum memory-wait cycles before mem_timeout is set (1..255).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 id_src_rn, id_src_rm  in  4 each  source registers of the instruction in ID.
REQ-006 id_two_src  in  1  id_src_rm is a real operand.
REQ-007 id_wb_en, id_mem_read  in  1 each  ID instruction writes back / is a load (pre-hazard masking).
REQ-008 id_dest  in  4  ID destination register.
REQ-009 branch_taken  in  1  branch resolved taken in EXE this cycle.
REQ-010 mem_req  in  1  MEM-stage instruction accesses data memory.
REQ-011 sram_ready  in  1  data memory completes the access this cycle.
REQ-012 fwd_cfg_we, fwd_cfg  in  1 each  write enable and value for the forwarding mode.
REQ-013 hazard  out  1  to ID stage; zeroes ID control outputs (bubble).
REQ-014 freeze_if  out  1  PC and IF/ID register hold.
REQ-015 flush  out  1  IF/ID cleared; ID/EXE receives a bubble.
REQ-016 freeze_pipe  out  1  all pipeline registers, including PC, hold.
REQ-017 mem_timeout  out  1  sticky memory-wait watchdog error.
REQ-018 stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-019 Scoreboard SHALL hold two slots, EXE {v, dest, ld} and MEM {v, dest}, mirroring the pipeline.
REQ-020 Each clock edge with freeze_pipe=0: MEM <= EXE; EXE <= {id_wb_en & ~hazard & ~flush, id_dest, id_mem_read}.
REQ-021 freeze_pipe=1: both slots hold.
REQ-022 match(x) = slot.v & slot.dest==x, where x is id_src_rn, or id_src_rm qualified by id_two_src.
REQ-023 Forwarding off: raw_hazard = match in EXE or MEM slot.
REQ-024 Forwarding on: raw_hazard = match in EXE slot with EXE.ld=1 only (load-use).
REQ-025 flush = branch_taken & ~freeze_pipe (combinational).
REQ-026 hazard = raw_hazard & ~flush.
REQ-027 freeze_if = hazard | freeze_pipe.
REQ-028 freeze_pipe = mem_req & ~sram_ready (combinational, zero latency).
REQ-029 Memory FSM states:
  - IDLE -> WAIT when freeze_pipe=1.
  - WAIT -> IDLE when sram_ready=1 or mem_req=0.
  - An 8-bit wait counter clears in IDLE and increments in WAIT.
REQ-030 When the wait counter reaches MEM_TIMEOUT, mem_timeout SHALL set and remain set until reset; the stall does not end.
REQ-031 The forwarding mode register loads fwd_cfg when fwd_cfg_we=1 and freeze_pipe=0; a write during freeze_pipe=1 is dropped.
REQ-032 stall_cycles increments by 1 each cycle freeze_if=1 and saturates at 16'hFFFF.
REQ-033 Simultaneous branch_taken and stall: stall wins; flush is deferred until the stall ends (the branch stays in EXE).
REQ-034 Simultaneous branch_taken and raw_hazard: flush wins; hazard=0; no double bubble.
REQ-035 Register 0..15 all participate in matching; there is no hardwired zero register.

Reset
REQ-036 rst=0 SHALL asynchronously clear:
  - both slot valid bits, dests and ld bits;
  - the FSM to IDLE and the wait counter to 0;
  - mem_timeout and stall_cycles to 0;
  - the forwarding mode to FWD_DEFAULT.
REQ-037 During reset and in the first cycle after it, hazard, freeze_if, flush and freeze_pipe SHALL be 0, given branch_taken=0 and mem_req=0.
REQ-038 Reset during WAIT SHALL abort the wait with no residual timeout.

Verification
REQ-039 Forwarding off; issue a write to R3, then a read of R3 as Rn -> hazard=1 for 2 cycles, freeze_if=1, stall_cycles=2.
REQ-040 Forwarding on; a load to R5 followed by an add reading R5 as Rm with id_two_src=1 -> hazard=1 for 1 cycle; a non-load producer -> hazard=0.
REQ-041 mem_req=1, sram_ready=0 for 3 cycles then 1 -> freeze_pipe=1 for 3 cycles; scoreboard unchanged; FSM back in IDLE; mem_timeout=0.
REQ-042 mem_req=1, sram_ready=0 held for MEM_TIMEOUT+2 cycles -> mem_timeout=1 and stays 1 after sram_ready returns.
REQ-043 branch_taken=1 together with raw_hazard -> flush=1, hazard=0; next EXE slot v=0; the same case under a memory stall -> flush=0 until sram_ready=1.
REQ-044 rst pulsed low mid-WAIT with stall_cycles=40 -> all outputs 0 immediately and the FSM in IDLE.
